// File: rtl/gpp_pkt_pkg.sv
// Shared packet-word definitions and FSM state type for the GPP egress demux.
package gpp_pkt_pkg;

    localparam int unsigned PKT_W = 134;

    // Tag field occupies the two top bits of every word
    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_MID  = 2'b11;
    localparam logic [1:0] TAG_TAIL = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        FWD_TX,
        FWD_HOST,
        DROP
    } state_e;

    // True when the word carries the tail tag (also covers single-word packets)
    function automatic logic is_tail(input logic [PKT_W-1:0] w);
        return w[PKT_W-1 -: 2] == TAG_TAIL;
    endfunction

endpackage

// File: rtl/demux_fwft_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_en_i acknowledges the word at dout_o.
// Writes while full and reads while empty are ignored.
module demux_fwft_fifo #(
    parameter int unsigned W     = 134,
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  din_i,
    input  logic          wr_en_i,
    input  logic          rd_en_i,
    output logic [W-1:0]  dout_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   usedw_o
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_wr, do_rd;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign usedw_o = cnt_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Accept / pop decisions and pointer/count next state
    always_comb begin
        do_wr    = wr_en_i && !full_o;
        do_rd    = rd_en_i && !empty_o;
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_wr && !do_rd) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_wr && do_rd) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Storage array; flushing is done by the pointers, so no reset here
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/gpp_demux.sv
// Egress splitter: buffers whole packets from GPP and steers each to TX or host by a
// destination bit in the head word; packets flagged invalid are drained and counted.
module gpp_demux
    import gpp_pkt_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned ALF_TH  = 192,
    parameter int unsigned DST_BIT = 127
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gpp2demux_data_wr,
    input  logic [PKT_W-1:0] gpp2demux_data,
    input  logic             gpp2demux_data_valid,
    input  logic             gpp2demux_data_valid_wr,
    output logic             demux2gpp_data_alf,
    output logic             demux2tx_data_wr,
    output logic [PKT_W-1:0] demux2tx_data,
    output logic             demux2tx_data_valid,
    output logic             demux2tx_data_valid_wr,
    input  logic             tx2demux_data_alf,
    output logic             demux2host_data_wr,
    output logic [PKT_W-1:0] demux2host_data,
    output logic             demux2host_data_valid,
    output logic             demux2host_data_valid_wr,
    input  logic             host2demux_data_alf,
    output logic [31:0]      tx_pkt_cnt,
    output logic [31:0]      host_pkt_cnt,
    output logic [31:0]      drop_pkt_cnt,
    output logic             ovf_err
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned VDEPTH  = DEPTH / 4;
    localparam int unsigned VAW     = $clog2(VDEPTH);
    localparam logic [AW:0] ALF_CNT = (AW + 1)'(ALF_TH);

    state_e state_q, state_d;

    logic [PKT_W-1:0] data_dout;
    logic             data_empty, data_full, data_rd;
    logic [AW:0]      data_usedw;
    logic [0:0]       vld_dout;
    logic             vld_empty, vld_full, vld_rd;
    logic [VAW:0]     unused_vld_usedw;

    logic             tx_wr_q, tx_wr_d, tx_valid_q, tx_valid_d, tx_vwr_q, tx_vwr_d;
    logic             host_wr_q, host_wr_d, host_valid_q, host_valid_d, host_vwr_q, host_vwr_d;
    logic [PKT_W-1:0] tx_data_q, tx_data_d, host_data_q, host_data_d;
    logic [31:0]      tx_cnt_q, tx_cnt_d, host_cnt_q, host_cnt_d, drop_cnt_q, drop_cnt_d;
    logic             ovf_q, ovf_d;

    demux_fwft_fifo #(
        .W     (PKT_W),
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .din_i   (gpp2demux_data),
        .wr_en_i (gpp2demux_data_wr),
        .rd_en_i (data_rd),
        .dout_o  (data_dout),
        .empty_o (data_empty),
        .full_o  (data_full),
        .usedw_o (data_usedw)
    );

    demux_fwft_fifo #(
        .W     (1),
        .DEPTH (VDEPTH)
    ) u_vld_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .din_i   (gpp2demux_data_valid),
        .wr_en_i (gpp2demux_data_valid_wr),
        .rd_en_i (vld_rd),
        .dout_o  (vld_dout),
        .empty_o (vld_empty),
        .full_o  (vld_full),
        .usedw_o (unused_vld_usedw)
    );

    assign demux2gpp_data_alf       = (data_usedw >= ALF_CNT);
    assign demux2tx_data_wr         = tx_wr_q;
    assign demux2tx_data            = tx_data_q;
    assign demux2tx_data_valid      = tx_valid_q;
    assign demux2tx_data_valid_wr   = tx_vwr_q;
    assign demux2host_data_wr       = host_wr_q;
    assign demux2host_data          = host_data_q;
    assign demux2host_data_valid    = host_valid_q;
    assign demux2host_data_valid_wr = host_vwr_q;
    assign tx_pkt_cnt               = tx_cnt_q;
    assign host_pkt_cnt             = host_cnt_q;
    assign drop_pkt_cnt             = drop_cnt_q;
    assign ovf_err                  = ovf_q;

    // FSM next state, FIFO pops, output-register next values and counters
    always_comb begin
        state_d      = state_q;
        data_rd      = 1'b0;
        vld_rd       = 1'b0;
        tx_wr_d      = 1'b0;
        tx_data_d    = '0;
        tx_valid_d   = 1'b0;
        tx_vwr_d     = 1'b0;
        host_wr_d    = 1'b0;
        host_data_d  = '0;
        host_valid_d = 1'b0;
        host_vwr_d   = 1'b0;
        tx_cnt_d     = tx_cnt_q;
        host_cnt_d   = host_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        ovf_d        = ovf_q | (gpp2demux_data_wr && data_full)
                             | (gpp2demux_data_valid_wr && vld_full);

        unique case (state_q)
            IDLE: begin
                // A queued flag means the whole packet is already in the data FIFO
                if (!vld_empty && !data_empty) begin
                    if (!vld_dout[0]) begin
                        state_d = DROP;
                    end else if (!data_dout[DST_BIT] && !tx2demux_data_alf) begin
                        state_d = FWD_TX;
                    end else if (data_dout[DST_BIT] && !host2demux_data_alf) begin
                        state_d = FWD_HOST;
                    end
                end
            end
            FWD_TX: begin
                if (!data_empty) begin
                    data_rd   = 1'b1;
                    tx_wr_d   = 1'b1;
                    tx_data_d = data_dout;
                    if (is_tail(data_dout)) begin
                        tx_valid_d = 1'b1;
                        tx_vwr_d   = 1'b1;
                        vld_rd     = 1'b1;
                        tx_cnt_d   = tx_cnt_q + 32'd1;
                        state_d    = IDLE;
                    end
                end
            end
            FWD_HOST: begin
                if (!data_empty) begin
                    data_rd     = 1'b1;
                    host_wr_d   = 1'b1;
                    host_data_d = data_dout;
                    if (is_tail(data_dout)) begin
                        host_valid_d = 1'b1;
                        host_vwr_d   = 1'b1;
                        vld_rd       = 1'b1;
                        host_cnt_d   = host_cnt_q + 32'd1;
                        state_d      = IDLE;
                    end
                end
            end
            DROP: begin
                if (!data_empty) begin
                    data_rd = 1'b1;
                    if (is_tail(data_dout)) begin
                        vld_rd     = 1'b1;
                        drop_cnt_d = drop_cnt_q + 32'd1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, output registers, counters and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tx_wr_q      <= 1'b0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            tx_vwr_q     <= 1'b0;
            host_wr_q    <= 1'b0;
            host_data_q  <= '0;
            host_valid_q <= 1'b0;
            host_vwr_q   <= 1'b0;
            tx_cnt_q     <= '0;
            host_cnt_q   <= '0;
            drop_cnt_q   <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_wr_q      <= tx_wr_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            tx_vwr_q     <= tx_vwr_d;
            host_wr_q    <= host_wr_d;
            host_data_q  <= host_data_d;
            host_valid_q <= host_valid_d;
            host_vwr_q   <= host_vwr_d;
            tx_cnt_q     <= tx_cnt_d;
            host_cnt_q   <= host_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            ovf_q        <= ovf_d;
        end
    end

endmodule

// File: tb/tb_gpp_demux.sv
// Directed scoreboard bench for gpp_demux: expected words are queued per path as packets are
// written and popped when the matching output strobe appears.
module tb_gpp_demux;
    import gpp_pkt_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             gpp2demux_data_wr = 1'b0;
    logic [PKT_W-1:0] gpp2demux_data = '0;
    logic             gpp2demux_data_valid = 1'b0;
    logic             gpp2demux_data_valid_wr = 1'b0;
    logic             demux2gpp_data_alf;
    logic             demux2tx_data_wr, demux2tx_data_valid, demux2tx_data_valid_wr;
    logic [PKT_W-1:0] demux2tx_data;
    logic             tx2demux_data_alf = 1'b0;
    logic             demux2host_data_wr, demux2host_data_valid, demux2host_data_valid_wr;
    logic [PKT_W-1:0] demux2host_data;
    logic             host2demux_data_alf = 1'b0;
    logic [31:0]      tx_pkt_cnt, host_pkt_cnt, drop_pkt_cnt;
    logic             ovf_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_tx = 0;
    int exp_host = 0;
    int host_tail_cyc = 0;
    int host_head_cyc = 0;
    int tx_head_cyc = 0;
    int alf_drop_cyc = 0;
    logic [PKT_W-1:0] tx_q[$];
    logic [PKT_W-1:0] host_q[$];
    logic [PKT_W-1:0] mon_tx_exp, mon_host_exp;

    gpp_demux u_dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .gpp2demux_data_wr        (gpp2demux_data_wr),
        .gpp2demux_data           (gpp2demux_data),
        .gpp2demux_data_valid     (gpp2demux_data_valid),
        .gpp2demux_data_valid_wr  (gpp2demux_data_valid_wr),
        .demux2gpp_data_alf       (demux2gpp_data_alf),
        .demux2tx_data_wr         (demux2tx_data_wr),
        .demux2tx_data            (demux2tx_data),
        .demux2tx_data_valid      (demux2tx_data_valid),
        .demux2tx_data_valid_wr   (demux2tx_data_valid_wr),
        .tx2demux_data_alf        (tx2demux_data_alf),
        .demux2host_data_wr       (demux2host_data_wr),
        .demux2host_data          (demux2host_data),
        .demux2host_data_valid    (demux2host_data_valid),
        .demux2host_data_valid_wr (demux2host_data_valid_wr),
        .host2demux_data_alf      (host2demux_data_alf),
        .tx_pkt_cnt               (tx_pkt_cnt),
        .host_pkt_cnt             (host_pkt_cnt),
        .drop_pkt_cnt             (drop_pkt_cnt),
        .ovf_err                  (ovf_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [PKT_W-1:0] obs, input logic [PKT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every strobe and checks framing
    always @(negedge clk) begin
        if (rst_n) begin
            chk("tx_bus_zero", PKT_W'(demux2tx_data_wr || demux2tx_data == '0), PKT_W'(1));
            chk("host_bus_zero", PKT_W'(demux2host_data_wr || demux2host_data == '0), PKT_W'(1));
            if (demux2tx_data_wr) begin
                chk("tx_host_quiet", PKT_W'(demux2host_data_wr), PKT_W'(0));
                if (tx_q.size() == 0) begin
                    chk("tx_unexpected", PKT_W'(demux2tx_data_wr), PKT_W'(0));
                end else begin
                    mon_tx_exp = tx_q.pop_front();
                    chk("tx_data", demux2tx_data, mon_tx_exp);
                    chk("tx_valid_wr", PKT_W'(demux2tx_data_valid_wr), PKT_W'(is_tail(mon_tx_exp)));
                    chk("tx_valid", PKT_W'(demux2tx_data_valid), PKT_W'(is_tail(mon_tx_exp)));
                    if (is_tail(mon_tx_exp)) exp_tx++;
                    if (mon_tx_exp[PKT_W-1 -: 2] == TAG_HEAD) tx_head_cyc = cyc;
                end
            end else begin
                chk("tx_vwr_idle", PKT_W'(demux2tx_data_valid_wr), PKT_W'(0));
            end
            if (demux2host_data_wr) begin
                chk("host_tx_quiet", PKT_W'(demux2tx_data_wr), PKT_W'(0));
                if (host_q.size() == 0) begin
                    chk("host_unexpected", PKT_W'(demux2host_data_wr), PKT_W'(0));
                end else begin
                    mon_host_exp = host_q.pop_front();
                    chk("host_data", demux2host_data, mon_host_exp);
                    chk("host_valid_wr", PKT_W'(demux2host_data_valid_wr),
                        PKT_W'(is_tail(mon_host_exp)));
                    chk("host_valid", PKT_W'(demux2host_data_valid), PKT_W'(is_tail(mon_host_exp)));
                    if (is_tail(mon_host_exp)) begin
                        exp_host++;
                        host_tail_cyc = cyc;
                    end
                    if (mon_host_exp[PKT_W-1 -: 2] == TAG_HEAD) host_head_cyc = cyc;
                end
            end else begin
                chk("host_vwr_idle", PKT_W'(demux2host_data_valid_wr), PKT_W'(0));
            end
        end
    end

    // Writes one packet word per cycle, flag strobed with the tail; queues it if forwarded
    task automatic send_pkt(input int n, input logic dst, input logic vld);
        logic [PKT_W-1:0] w;
        logic [1:0] tag;
        for (int i = 0; i < n; i++) begin
            tag = (i == n - 1) ? TAG_TAIL : ((i == 0) ? TAG_HEAD : TAG_MID);
            w = {tag, 4'hF, $urandom, $urandom, $urandom, $urandom};
            if (i == 0) w[127] = dst;
            if (vld) begin
                if (dst) host_q.push_back(w);
                else tx_q.push_back(w);
            end
            gpp2demux_data_wr       = 1'b1;
            gpp2demux_data          = w;
            gpp2demux_data_valid_wr = (i == n - 1);
            gpp2demux_data_valid    = (i == n - 1) ? vld : 1'b0;
            @(negedge clk);
        end
        gpp2demux_data_wr       = 1'b0;
        gpp2demux_data          = '0;
        gpp2demux_data_valid_wr = 1'b0;
        gpp2demux_data_valid    = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int maxc);
        int n = 0;
        while ((tx_q.size() != 0 || host_q.size() != 0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, PKT_W'(tx_q.size() + host_q.size()), PKT_W'(0));
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_counts(input string tag, input int d);
        chk({tag, "_tx_cnt"}, PKT_W'(tx_pkt_cnt), PKT_W'(exp_tx));
        chk({tag, "_host_cnt"}, PKT_W'(host_pkt_cnt), PKT_W'(exp_host));
        chk({tag, "_drop_cnt"}, PKT_W'(drop_pkt_cnt), PKT_W'(d));
    endtask

    initial begin
        int n;
        // Reset state
        #12;
        chk("rst_tx_wr", PKT_W'(demux2tx_data_wr), PKT_W'(0));
        chk("rst_host_wr", PKT_W'(demux2host_data_wr), PKT_W'(0));
        chk("rst_alf", PKT_W'(demux2gpp_data_alf), PKT_W'(0));
        chk("rst_ovf", PKT_W'(ovf_err), PKT_W'(0));
        chk_counts("rst", 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: four-word TX packet
        send_pkt(4, 1'b0, 1'b1);
        wait_drain("t1_drain", 50);
        chk_counts("t1", 0);

        // 2: host packet then TX packet back to back, one idle cycle between them
        send_pkt(3, 1'b1, 1'b1);
        send_pkt(2, 1'b0, 1'b1);
        wait_drain("t2_drain", 50);
        chk("t2_gap", PKT_W'(tx_head_cyc - host_tail_cyc), PKT_W'(2));
        chk_counts("t2", 0);

        // 3: invalid packet drained silently, then single-word packets both ways
        send_pkt(5, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        chk_counts("t3", 1);
        chk("t3_data_empty", PKT_W'(u_dut.u_data_fifo.empty_o), PKT_W'(1));
        chk("t3_vld_empty", PKT_W'(u_dut.u_vld_fifo.empty_o), PKT_W'(1));
        send_pkt(1, 1'b0, 1'b1);
        send_pkt(1, 1'b1, 1'b1);
        wait_drain("t3_single_drain", 50);
        chk_counts("t3_single", 1);

        // 4: host alf holds the packet; release starts it; alf mid-packet is ignored
        host2demux_data_alf = 1'b1;
        send_pkt(6, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        chk("t4_hold_q", PKT_W'(host_q.size()), PKT_W'(6));
        chk_counts("t4_hold", 1);
        host2demux_data_alf = 1'b0;
        alf_drop_cyc = cyc;
        repeat (3) @(negedge clk);
        host2demux_data_alf = 1'b1;
        wait_drain("t4_drain", 50);
        chk("t4_start", PKT_W'(host_head_cyc - alf_drop_cyc), PKT_W'(2));
        chk_counts("t4", 1);
        host2demux_data_alf = 1'b0;

        // 6: reset in the middle of a ten-word TX packet
        send_pkt(10, 1'b0, 1'b1);
        n = 0;
        while (tx_q.size() > 6 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t6_started", PKT_W'(tx_q.size() <= 6), PKT_W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        tx_q.delete();
        host_q.delete();
        exp_tx = 0;
        exp_host = 0;
        chk("t6_tx_wr", PKT_W'(demux2tx_data_wr), PKT_W'(0));
        chk("t6_tx_data", demux2tx_data, PKT_W'(0));
        chk_counts("t6_rst", 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_no_tail", PKT_W'(exp_tx), PKT_W'(0));
        send_pkt(3, 1'b0, 1'b1);
        wait_drain("t6_drain", 50);
        chk_counts("t6", 0);

        // 5: fill the data FIFO without flags; alf threshold then overflow
        for (int i = 0; i < 191; i++) begin
            gpp2demux_data_wr = 1'b1;
            gpp2demux_data    = {TAG_MID, 4'hF, 96'd0, 32'(i)};
            @(negedge clk);
        end
        chk("t5_alf_191", PKT_W'(demux2gpp_data_alf), PKT_W'(0));
        @(negedge clk);
        chk("t5_alf_192", PKT_W'(demux2gpp_data_alf), PKT_W'(1));
        for (int i = 0; i < 64; i++) @(negedge clk);
        chk("t5_ovf_full", PKT_W'(ovf_err), PKT_W'(0));
        @(negedge clk);
        gpp2demux_data_wr = 1'b0;
        chk("t5_ovf_set", PKT_W'(ovf_err), PKT_W'(1));
        repeat (5) @(negedge clk);
        chk("t5_ovf_sticky", PKT_W'(ovf_err), PKT_W'(1));
        chk("t5_alf_hold", PKT_W'(demux2gpp_data_alf), PKT_W'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
